// File: rtl/jkff_pkg.sv
// Shared definitions for the JK flip-flop bank arbiter: op codes, FSM states
// and the op -> {J, K} drive lookup.
package jkff_pkg;

  // Requester op codes
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  // Drive pairs presented to the addressed flip-flop, packed as {J, K}
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_VERIFY = 2'd2
  } state_e;

  // Map an op code onto the {J, K} pair for the addressed bit.
  function automatic logic [1:0] op_to_jk(input logic [1:0] op);
    logic [1:0] jk;
    case (op)
      OP_HOLD: jk = JK_HOLD;
      OP_CLR:  jk = JK_CLR;
      OP_SET:  jk = JK_SET;
      default: jk = JK_TGL;
    endcase
    return jk;
  endfunction

  // Value the addressed bit must read back as one cycle after the drive.
  function automatic logic exp_bit(input logic [1:0] op, input logic q_now);
    logic e;
    case (op)
      OP_HOLD: e = q_now;
      OP_CLR:  e = 1'b0;
      OP_SET:  e = 1'b1;
      default: e = ~q_now;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PTRW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic            gnt_valid,
  output logic [PTRW-1:0] gnt_idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [PTRW:0]     sum;

  // Rotate so that position 0 is the highest-priority requester.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NREQ-1:0];

  // Find the first set bit of the rotated vector and map it back to a requester.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_valid && rot[k]) begin
        gnt_valid = 1'b1;
        sum       = {1'b0, ptr} + (PTRW+1)'(k);
        if (sum >= (PTRW+1)'(NREQ)) begin
          sum = sum - (PTRW+1)'(NREQ);
        end
        gnt_idx = sum[PTRW-1:0];
      end
    end
  end

endmodule

// File: rtl/jkff_bank_arbiter.sv
// Round-robin arbiter sharing one bank of external JK flip-flops among NREQ
// requesters. Each grant drives J/K on one bit for one cycle, reads Q back on
// the following cycle and acks the requester with a pass/fail flag.
module jkff_bank_arbiter
  import jkff_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic                 CK,
  input  logic                 RB,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  input  logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     J,
  output logic [WIDTH-1:0]     K,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic                 busy
);

  localparam int unsigned PTRW = $clog2(NREQ);

  state_e            state_q;
  logic [PTRW-1:0]   ptr_q;
  logic [PTRW-1:0]   gnt_q;
  logic [IDXW-1:0]   idx_q;
  logic              exp_q;
  logic [WIDTH-1:0]  j_q;
  logic [WIDTH-1:0]  k_q;
  logic [NREQ-1:0]   ack_q;
  logic              err_q;

  logic              gnt_valid;
  logic [PTRW-1:0]   gnt_idx;
  logic [1:0]        sel_op;
  logic [IDXW-1:0]   sel_idx;
  logic [1:0]        sel_jk;
  logic [WIDTH-1:0]  sel_mask;

  // Indices at or above WIDTH address no flip-flop.
  function automatic logic idx_legal(input logic [IDXW-1:0] i);
    return 32'(i) < WIDTH;
  endfunction

  // Q bit at index i; reads as 0 for an illegal index.
  function automatic logic bit_at(input logic [WIDTH-1:0] q, input logic [IDXW-1:0] i);
    logic b;
    b = 1'b0;
    for (int n = 0; n < WIDTH; n++) begin
      if (i == IDXW'(n)) b = q[n];
    end
    return b;
  endfunction

  // One-hot bank mask for index i; all-zero for an illegal index.
  function automatic logic [WIDTH-1:0] idx_mask(input logic [IDXW-1:0] i);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int n = 0; n < WIDTH; n++) begin
      if (i == IDXW'(n)) m[n] = 1'b1;
    end
    return m;
  endfunction

  // One-hot requester vector for ack.
  function automatic logic [NREQ-1:0] req_onehot(input logic [PTRW-1:0] g);
    logic [NREQ-1:0] v;
    v = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (g == PTRW'(n)) v[n] = 1'b1;
    end
    return v;
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_rr_pick (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Select the winning requester's op and index fields.
  always_comb begin
    sel_op  = '0;
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PTRW'(i)) begin
        sel_op  = op[2*i +: 2];
        sel_idx = idx[IDXW*i +: IDXW];
      end
    end
  end

  // Drive pair and bit mask for the transaction about to be issued.
  always_comb begin
    sel_jk   = op_to_jk(sel_op);
    sel_mask = idx_mask(sel_idx);
  end

  // Transaction FSM with registered J/K, ack and err.
  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      exp_q   <= 1'b0;
      j_q     <= '0;
      k_q     <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= '0;
          err_q <= 1'b0;
          j_q   <= '0;
          k_q   <= '0;
          if (gnt_valid) begin
            gnt_q   <= gnt_idx;
            idx_q   <= sel_idx;
            // Expected value is based on Q before the bank sees the drive.
            exp_q   <= exp_bit(sel_op, bit_at(Q, sel_idx));
            j_q     <= sel_jk[1] ? sel_mask : '0;
            k_q     <= sel_jk[0] ? sel_mask : '0;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Bank captures the drive on this edge; release it immediately.
          j_q     <= '0;
          k_q     <= '0;
          state_q <= ST_VERIFY;
        end
        ST_VERIFY: begin
          ack_q   <= req_onehot(gnt_q);
          err_q   <= !idx_legal(idx_q) || (bit_at(Q, idx_q) != exp_q);
          ptr_q   <= (gnt_q == PTRW'(NREQ - 1)) ? '0 : gnt_q + PTRW'(1);
          state_q <= ST_IDLE;
        end
        default: begin
          j_q     <= '0;
          k_q     <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign J    = j_q;
  assign K    = k_q;
  assign ack  = ack_q;
  assign err  = err_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jkff_bank_arbiter.sv
// Self-checking bench for jkff_bank_arbiter with a behavioural JK bank model
// and an ack scoreboard.
module tb_jkff_bank_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 6;
  localparam int unsigned IDXW  = 3;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] CLR  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TGL  = 2'b11;

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic            err;
  } exp_t;

  logic                 CK = 1'b0;
  logic                 RB = 1'b0;
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    op;
  logic [IDXW*NREQ-1:0] idx;
  logic [WIDTH-1:0]     Q;
  logic [WIDTH-1:0]     J;
  logic [WIDTH-1:0]     K;
  logic [NREQ-1:0]      ack;
  logic                 err;
  logic                 busy;

  logic [WIDTH-1:0]     bank_q;
  logic [WIDTH-1:0]     stuck0;
  exp_t                 sb_q[$];
  int unsigned          total = 0;
  int unsigned          bad = 0;

  jkff_bank_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) dut (
    .CK   (CK),
    .RB   (RB),
    .req  (req),
    .op   (op),
    .idx  (idx),
    .Q    (Q),
    .J    (J),
    .K    (K),
    .ack  (ack),
    .err  (err),
    .busy (busy)
  );

  always #5 CK = ~CK;

  // External bank: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits on readback
  assign Q = bank_q & ~stuck0;
  always @(posedge CK) bank_q <= (J & ~bank_q) | (~K & bank_q);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input int r, input logic e);
    exp_t x;
    x.ack    = '0;
    x.ack[r] = 1'b1;
    x.err    = e;
    sb_q.push_back(x);
  endtask

  // Scoreboard: every ack pulse must match the oldest outstanding expectation
  always @(negedge CK) begin : mon
    exp_t x;
    if (RB && ack != '0) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        x = sb_q.pop_front();
        check_eq("sb_ack", 32'(ack), 32'(x.ack));
        check_eq("sb_err", 32'(err), 32'(x.err));
      end
    end
    if (RB && (J | K) != '0) check_eq("jk_single", $countones(J | K), 1);
  end

  // One isolated transaction with exact per-cycle checks of J/K, busy and latency
  task automatic do_op(input int r, input logic [1:0] o, input int i, input logic e,
                       input string tag);
    logic [WIDTH-1:0] m;
    m = (i < int'(WIDTH)) ? WIDTH'(1) << i : '0;
    @(negedge CK);
    req[r]               = 1'b1;
    op[2*r +: 2]         = o;
    idx[IDXW*r +: IDXW]  = IDXW'(i);
    push_exp(r, e);
    @(posedge CK);
    @(negedge CK);
    check_eq({tag, "_issue_j"}, 32'(J), 32'(o[1] ? m : '0));
    check_eq({tag, "_issue_k"}, 32'(K), 32'(o[0] ? m : '0));
    check_eq({tag, "_issue_busy"}, 32'(busy), 32'd1);
    @(negedge CK);
    check_eq({tag, "_verify_jk"}, 32'(J | K), 32'd0);
    check_eq({tag, "_verify_busy"}, 32'(busy), 32'd1);
    @(negedge CK);
    check_eq({tag, "_ack_lat"}, 32'(ack[r]), 32'd1);
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    req[r] = 1'b0;
  endtask

  // Hold a request mask until n acks have been seen (bounded), then drop it
  task automatic run_held(input logic [NREQ-1:0] mask, input int n, input string tag);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    @(negedge CK);
    req = mask;
    while (seen < n && cyc < 60) begin
      @(negedge CK);
      cyc++;
      if (ack != '0) seen++;
    end
    req = '0;
    check_eq({tag, "_acks"}, 32'(seen), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    req    = '0;
    op     = '0;
    idx    = '0;
    bank_q = '0;
    stuck0 = '0;
    RB     = 1'b0;
    repeat (2) @(negedge CK);
    RB = 1'b1;
    @(negedge CK);
    check_eq("rst_j", 32'(J), 32'd0);
    check_eq("rst_k", 32'(K), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // Reset asserted between edges while a grant is in flight
    op  = {NREQ{TGL}};
    idx = '0;
    req = '1;
    @(posedge CK);
    #2;
    check_eq("t1_granted", 32'(busy), 32'd1);
    check_eq("t1_drive", 32'(J & K), 32'h1);
    RB = 1'b0;
    #1;
    check_eq("t1_async_jk", 32'(J | K), 32'd0);
    check_eq("t1_async_ack", 32'(ack), 32'd0);
    check_eq("t1_async_busy", 32'(busy), 32'd0);
    req = '0;
    @(negedge CK);
    RB = 1'b1;
    repeat (5) @(negedge CK);
    check_eq("t1_bank", 32'(Q), 32'd0);

    // Single SET
    do_op(1, SET, 5, 1'b0, "t2");
    check_eq("t2_q", 32'(Q), 32'h20);

    // Toggle bit 0 twice
    do_op(0, TGL, 0, 1'b0, "t3a");
    check_eq("t3a_q0", 32'(Q[0]), 32'd1);
    do_op(0, TGL, 0, 1'b0, "t3b");
    check_eq("t3b_q0", 32'(Q[0]), 32'd0);

    // Illegal index and stuck-at readback
    do_op(2, SET, 7, 1'b1, "t5a");
    check_eq("t5a_q", 32'(Q), 32'h20);
    stuck0 = 6'b000100;
    do_op(3, SET, 2, 1'b1, "t5b");
    stuck0 = '0;
    check_eq("t5b_bank", 32'(bank_q[2]), 32'd1);

    // Idle reset pulse puts the pointer back at requester 0
    @(negedge CK);
    RB = 1'b0;
    @(negedge CK);
    RB = 1'b1;

    // Round robin with 0,1,3 held
    op  = {NREQ{HOLD}};
    idx = {3'd3, 3'd2, 3'd1, 3'd0};
    push_exp(0, 1'b0); push_exp(1, 1'b0); push_exp(3, 1'b0);
    push_exp(0, 1'b0); push_exp(1, 1'b0); push_exp(3, 1'b0);
    run_held(4'b1011, 6, "t4");
    repeat (4) @(negedge CK);
    check_eq("t4_q", 32'(Q), 32'h24);

    // Reset during VERIFY aborts without ack and clears the pointer
    do_op(0, HOLD, 0, 1'b0, "t6pre");
    @(negedge CK);
    req[1]  = 1'b1;
    op[3:2] = HOLD;
    idx[5:3] = 3'd1;
    @(posedge CK);
    @(negedge CK);
    @(negedge CK);
    check_eq("t6_in_verify", 32'(busy), 32'd1);
    RB = 1'b0;
    #1;
    check_eq("t6_abort_jk", 32'(J | K), 32'd0);
    check_eq("t6_abort_ack", 32'(ack), 32'd0);
    check_eq("t6_abort_busy", 32'(busy), 32'd0);
    req = '0;
    @(negedge CK);
    RB = 1'b1;
    repeat (4) @(negedge CK);
    push_exp(0, 1'b0);
    push_exp(2, 1'b0);
    run_held(4'b0101, 2, "t6");

    repeat (4) @(negedge CK);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
